// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared types and constants for the instruction-fetch stage
// Package if_pkg: fetch FSM state enum, word/PC width, halt opcode, NOP bubble word.
// Ports: none (package).
package if_pkg;
   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetch_state_e;

   localparam logic [5:0] OPC_HALT = 6'h11;
   localparam word_t      NOP      = 32'h0000_0000;

   function automatic logic is_halt(input word_t w, input logic [5:0] opc);
      return (w[31:26] == opc);
   endfunction
endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - fetch-stage bus: hazard/redirect inputs, imem port, IF/ID outputs
// Interface if_fetch_stage_if groups every non-clock signal of if_fetch_stage.
// Signals: stall, redirect, redirect_pc (control in); imem_addr (out) / imem_data (in);
//          if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, halted (out);
//          perf_fetched, perf_bubbles (out, only when IF_PERF_CNT_EN is defined).
// Modports: master = fetch stage, slave = surrounding pipeline / memory.
interface if_fetch_stage_if;
   import if_pkg::*;

   logic  stall;
   logic  redirect;
   word_t redirect_pc;
   word_t imem_addr;
   word_t imem_data;
   word_t if_id_instr;
   word_t if_id_pc;
   word_t if_id_pc_plus4;
   logic  if_id_valid;
   logic  halted;
`ifdef IF_PERF_CNT_EN
   word_t perf_fetched;
   word_t perf_bubbles;

   modport master (
      input  stall, redirect, redirect_pc, imem_data,
      output imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, halted,
             perf_fetched, perf_bubbles
   );
   modport slave (
      output stall, redirect, redirect_pc, imem_data,
      input  imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, halted,
             perf_fetched, perf_bubbles
   );
`else
   modport master (
      input  stall, redirect, redirect_pc, imem_data,
      output imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, halted
   );
   modport slave (
      output stall, redirect, redirect_pc, imem_data,
      input  imem_addr, if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, halted
   );
`endif
endinterface

// File: rtl/if_fetch_stage_pc_gen.sv
// rtl/if_fetch_stage_pc_gen.sv - PC register with redirect/hold/+4 next-PC selection
// Module if_pc_gen.
// Ports: clk, rst (async, active-high); i_load (take i_target); i_advance (pc+4);
//        i_target (redirect address, low 2 bits dropped); o_pc (PC register); o_pc_plus4.
module if_pc_gen
   import if_pkg::*;
#(
   parameter word_t RESET_PC = 32'h0000_0000
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  i_load,
   input  logic  i_advance,
   input  word_t i_target,
   output word_t o_pc,
   output word_t o_pc_plus4
);
   word_t r_pc;
   word_t w_next;
   word_t w_pc_plus4;

   // 32-bit add wraps 32'hFFFF_FFFC to 0 naturally.
   assign w_pc_plus4 = r_pc + 32'd4;

   always_comb begin
      w_next = r_pc;
      if (i_load)
         w_next = i_target & ~32'd3;
      else if (i_advance)
         w_next = w_pc_plus4;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_pc <= RESET_PC;
      else
         r_pc <= w_next;
   end

   assign o_pc       = r_pc;
   assign o_pc_plus4 = w_pc_plus4;
endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: PC, IF/ID register, stall/redirect/halt FSM
// Module if_fetch_stage. Optional feature macro: IF_PERF_CNT_EN (adds perf_fetched/perf_bubbles).
// Ports: clk (rising edge), rst (async, active-high), bus (if_fetch_stage_if.master):
//        stall, redirect, redirect_pc in; imem_addr out / imem_data in;
//        if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, halted out.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter word_t      RESET_PC     = 32'h0000_0000,
   parameter word_t      NOP_INSTR    = NOP,
   parameter logic [5:0] HALT_OPCODE  = OPC_HALT,
   parameter int         DRAIN_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   if_fetch_stage_if.master bus
);
   localparam int              CW       = $clog2(DRAIN_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DRAIN_CYCLES - 1);

   fetch_state_e  r_state;
   logic [CW-1:0] r_cnt;
   word_t         r_instr;
   word_t         r_ipc;
   word_t         r_ip4;
   logic          r_valid;
   logic          r_halted;

   word_t w_pc;
   word_t w_pc_plus4;
   logic  w_live;
   logic  w_take_redirect;
   logic  w_advance;

   // HALTED ignores every control input, so redirect only counts while live.
   assign w_live          = (r_state != HALTED);
   assign w_take_redirect = w_live && bus.redirect;
   // PC advances only on a normal RUN cycle; in DRAIN it sits on the word after the halt.
   assign w_advance       = (r_state == RUN) && !bus.redirect && !bus.stall;

   if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_take_redirect),
      .i_advance  (w_advance),
      .i_target   (bus.redirect_pc),
      .o_pc       (w_pc),
      .o_pc_plus4 (w_pc_plus4)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= RUN;
         r_cnt    <= '0;
         r_instr  <= NOP_INSTR;
         r_ipc    <= '0;
         r_ip4    <= '0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            RUN: begin
               if (bus.redirect) begin
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
               end else if (!bus.stall) begin
                  r_instr <= bus.imem_data;
                  r_ipc   <= w_pc;
                  r_ip4   <= w_pc_plus4;
                  r_valid <= 1'b1;
                  if (is_halt(bus.imem_data, HALT_OPCODE)) begin
                     r_state <= DRAIN;
                     r_cnt   <= '0;
                  end
               end
            end
            DRAIN: begin
               if (bus.redirect) begin
                  // Halt was on a mispredicted path: resume fetching at the target.
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end else if (!bus.stall) begin
                  r_instr <= NOP_INSTR;
                  r_valid <= 1'b0;
                  r_cnt   <= r_cnt + 1'b1;
                  if (r_cnt == CNT_LAST) begin
                     r_state  <= HALTED;
                     r_halted <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_addr      = w_pc;
   assign bus.if_id_instr    = r_instr;
   assign bus.if_id_pc       = r_ipc;
   assign bus.if_id_pc_plus4 = r_ip4;
   assign bus.if_id_valid    = r_valid;
   assign bus.halted         = r_halted;

`ifdef IF_PERF_CNT_EN
   word_t r_fetched;
   word_t r_bubbles;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetched <= '0;
         r_bubbles <= '0;
      end else begin
         if (w_advance && (r_fetched != 32'hFFFF_FFFF))
            r_fetched <= r_fetched + 32'd1;
         if (w_live && (bus.stall || bus.redirect) && (r_bubbles != 32'hFFFF_FFFF))
            r_bubbles <= r_bubbles + 32'd1;
      end
   end

   assign bus.perf_fetched = r_fetched;
   assign bus.perf_bubbles = r_bubbles;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage against a behavioural model
module tb_if_fetch_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errs = 0;
   int   chks = 0;

   logic [31:0] mem [256];

   // Reference model: architectural state of the fetch stage.
   logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
   logic        m_valid, m_halted;
   int          m_mode;   // 0 fetching, 1 draining after halt, 2 halted
   int          m_drain;
   int          m_fet, m_bub;

   if_fetch_stage_if bus ();

   if_fetch_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.imem_data = mem[bus.imem_addr[9:2]];

   always #5 clk = ~clk;

   function automatic logic [129:0] obs_vec();
      return {bus.imem_addr, bus.if_id_valid, bus.halted, bus.if_id_instr,
              m_valid ? bus.if_id_pc : 32'h0, m_valid ? bus.if_id_pc_plus4 : 32'h0};
   endfunction

   function automatic logic [129:0] exp_vec();
      return {m_pc, m_valid, m_halted, m_instr,
              m_valid ? m_ipc : 32'h0, m_valid ? m_ip4 : 32'h0};
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_ip4 = 32'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_mode = 0; m_drain = 0; m_fet = 0; m_bub = 0;
   endtask

   task automatic fill_mem();
      logic [31:0] w;
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         if (w[31:26] == 6'h11) w[26] = ~w[26];
         mem[i] = w;
      end
   endtask

   // Holds rst across one rising edge and releases it between edges.
   task automatic do_reset();
      rst = 1'b1;
      bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Applies one cycle of inputs to DUT and model; returns at 1 time unit after the edge.
   task automatic step(input logic s, input logic r, input logic [31:0] rpc);
      logic [31:0] w;
      bus.stall = s; bus.redirect = r; bus.redirect_pc = rpc;
      if (m_mode != 2) begin
         if (r) begin
            m_bub++;
            m_pc = {rpc[31:2], 2'b00};
            m_instr = 32'h0; m_valid = 1'b0;
            m_mode = 0; m_drain = 0;
         end else if (s) begin
            m_bub++;
         end else if (m_mode == 0) begin
            w = mem[m_pc[9:2]];
            m_instr = w; m_ipc = m_pc; m_ip4 = m_pc + 32'd4; m_valid = 1'b1;
            m_fet++;
            m_pc = m_pc + 32'd4;
            if (w[31:26] == 6'h11) begin m_mode = 1; m_drain = 0; end
         end else begin
            m_instr = 32'h0; m_valid = 1'b0;
            m_drain++;
            if (m_drain == 4) begin m_mode = 2; m_halted = 1'b1; end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
      fill_mem();
      #2;
      chks++; if (bus.imem_addr !== 32'h0) begin errs++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, 32'h0); end
      chks++; if (bus.if_id_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", bus.if_id_valid); end
      chks++; if (bus.if_id_instr !== 32'h0) begin errs++; $display("FAIL reset_instr got=%h exp=0", bus.if_id_instr); end
      chks++; if (bus.if_id_pc !== 32'h0 || bus.if_id_pc_plus4 !== 32'h0) begin errs++; $display("FAIL reset_pcs got=%h/%h exp=0/0", bus.if_id_pc, bus.if_id_pc_plus4); end
      chks++; if (bus.halted !== 1'b0) begin errs++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
      do_reset();
   endtask

   task automatic test_fetch();
      mem[0] = 32'h2001_0005; mem[1] = 32'h2002_0007;
      step(0, 0, 0);
      chks++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL fetch1 got=%h exp=%h", obs_vec(), exp_vec()); end
      chks++; if (bus.if_id_pc !== 32'h0 || bus.if_id_instr !== 32'h2001_0005 || bus.if_id_valid !== 1'b1 || bus.imem_addr !== 32'h4)
         begin errs++; $display("FAIL fetch1_const got pc=%h instr=%h v=%b addr=%h exp pc=0 instr=20010005 v=1 addr=4", bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.imem_addr); end
      step(0, 0, 0);
      chks++; if (bus.if_id_pc !== 32'h4 || bus.if_id_instr !== 32'h2002_0007 || bus.imem_addr !== 32'h8)
         begin errs++; $display("FAIL fetch2_const got pc=%h instr=%h addr=%h exp pc=4 instr=20020007 addr=8", bus.if_id_pc, bus.if_id_instr, bus.imem_addr); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 2; i++) begin
         step(1, 0, 0);
         chks++; if (obs_vec() !== exp_vec() || bus.imem_addr !== 32'h8 || bus.if_id_pc !== 32'h4)
            begin errs++; $display("FAIL stall_hold got=%h exp=%h", obs_vec(), exp_vec()); end
      end
      step(0, 0, 0);
      chks++; if (bus.imem_addr !== 32'hC || bus.if_id_pc !== 32'h8 || obs_vec() !== exp_vec())
         begin errs++; $display("FAIL stall_resume got addr=%h pc=%h exp addr=c pc=8", bus.imem_addr, bus.if_id_pc); end
   endtask

   task automatic test_redirect();
      step(0, 0, 0);
      chks++; if (bus.imem_addr !== 32'h10) begin errs++; $display("FAIL redir_pre got=%h exp=10", bus.imem_addr); end
      step(0, 1, 32'h43);
      chks++; if (bus.imem_addr !== 32'h40 || bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0)
         begin errs++; $display("FAIL redirect got addr=%h v=%b instr=%h exp addr=40 v=0 instr=0", bus.imem_addr, bus.if_id_valid, bus.if_id_instr); end
      step(1, 1, 32'h81);
      chks++; if (bus.imem_addr !== 32'h80 || bus.if_id_valid !== 1'b0 || obs_vec() !== exp_vec())
         begin errs++; $display("FAIL stall_redirect got addr=%h v=%b exp addr=80 v=0", bus.imem_addr, bus.if_id_valid); end
      step(0, 0, 0);
      chks++; if (obs_vec() !== exp_vec() || bus.if_id_pc !== 32'h80)
         begin errs++; $display("FAIL redirect_fetch got=%h exp=%h", obs_vec(), exp_vec()); end
      step(0, 1, 32'hFFFF_FFFE);
      step(0, 0, 0);
      chks++; if (bus.imem_addr !== 32'h0 || bus.if_id_pc !== 32'hFFFF_FFFC || bus.if_id_pc_plus4 !== 32'h0)
         begin errs++; $display("FAIL wrap got addr=%h pc=%h pc4=%h exp 0/fffffffc/0", bus.imem_addr, bus.if_id_pc, bus.if_id_pc_plus4); end
   endtask

   task automatic test_halt();
      do_reset();
      mem[5] = 32'h4400_0000;
      for (int i = 0; i < 6; i++) step(0, 0, 0);
      chks++; if (bus.if_id_instr !== 32'h4400_0000 || bus.if_id_valid !== 1'b1 || bus.imem_addr !== 32'h18)
         begin errs++; $display("FAIL halt_latch got instr=%h v=%b addr=%h exp 44000000/1/18", bus.if_id_instr, bus.if_id_valid, bus.imem_addr); end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0);
         chks++; if (obs_vec() !== exp_vec() || bus.halted !== (i == 3))
            begin errs++; $display("FAIL halt_drain%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
      end
      step(1, 1, 32'h100);
      chks++; if (bus.halted !== 1'b1 || bus.imem_addr !== 32'h18 || bus.if_id_valid !== 1'b0)
         begin errs++; $display("FAIL halted_frozen got h=%b addr=%h v=%b exp 1/18/0", bus.halted, bus.imem_addr, bus.if_id_valid); end
      do_reset();
      for (int i = 0; i < 6; i++) step(0, 0, 0);
      step(0, 0, 0);
      step(1, 0, 0);
      step(1, 1, 32'h0);
      chks++; if (bus.imem_addr !== 32'h0 || bus.halted !== 1'b0 || bus.if_id_valid !== 1'b0)
         begin errs++; $display("FAIL drain_redirect got addr=%h h=%b v=%b exp 0/0/0", bus.imem_addr, bus.halted, bus.if_id_valid); end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0);
         chks++; if (obs_vec() !== exp_vec() || bus.halted !== 1'b0)
            begin errs++; $display("FAIL rerun%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
      end
      mem[5] = 32'h2000_0000;
   endtask

   task automatic test_random();
      logic s, r;
      fill_mem();
      for (int i = 0; i < 4; i++) mem[$urandom_range(255, 0)] = {6'h11, 26'($urandom)};
      do_reset();
      for (int i = 0; i < 400; i++) begin
         s = ($urandom_range(3, 0) == 0);
         r = ($urandom_range(7, 0) == 0);
         step(s, r, $urandom & 32'h3FF);
         chks++; if (obs_vec() !== exp_vec()) begin errs++; $display("FAIL random%0d got=%h exp=%h", i, obs_vec(), exp_vec()); end
         if (m_halted) do_reset();
      end
   endtask

   task automatic test_async_reset();
      fill_mem();
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      bus.stall = 1'b1;
      #3 rst = 1'b1;
      #1;
      chks++; if (bus.imem_addr !== 32'h0 || bus.if_id_valid !== 1'b0 || bus.if_id_instr !== 32'h0 || bus.if_id_pc !== 32'h0)
         begin errs++; $display("FAIL async_stall got addr=%h v=%b instr=%h pc=%h exp all 0", bus.imem_addr, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc); end
      do_reset();
      mem[2] = 32'h4400_0001;
      for (int i = 0; i < 4; i++) step(0, 0, 0);
      #3 rst = 1'b1;
      #1;
      chks++; if (bus.imem_addr !== 32'h0 || bus.halted !== 1'b0 || bus.if_id_valid !== 1'b0)
         begin errs++; $display("FAIL async_drain got addr=%h h=%b v=%b exp 0/0/0", bus.imem_addr, bus.halted, bus.if_id_valid); end
      do_reset();
      mem[2] = 32'h2000_0000;
      step(0, 0, 0);
      step(0, 0, 0);
      chks++; if (obs_vec() !== exp_vec() || bus.if_id_pc !== 32'h4)
         begin errs++; $display("FAIL async_restart got=%h exp=%h", obs_vec(), exp_vec()); end
   endtask

`ifdef IF_PERF_CNT_EN
   task automatic test_perf();
      fill_mem();
      do_reset();
      chks++; if (bus.perf_fetched !== 32'h0 || bus.perf_bubbles !== 32'h0)
         begin errs++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", bus.perf_fetched, bus.perf_bubbles); end
      for (int i = 0; i < 10; i++) step(0, 0, 0);
      step(1, 0, 0);
      step(1, 0, 0);
      chks++; if (bus.perf_fetched !== 32'd10 || bus.perf_bubbles !== 32'd2)
         begin errs++; $display("FAIL perf_counts got=%0d/%0d exp=10/2", bus.perf_fetched, bus.perf_bubbles); end
      for (int i = 0; i < 60; i++) step($urandom_range(2, 0) == 0, $urandom_range(5, 0) == 0, $urandom & 32'h3FC);
      chks++; if (bus.perf_fetched !== 32'(m_fet) || bus.perf_bubbles !== 32'(m_bub))
         begin errs++; $display("FAIL perf_random got=%0d/%0d exp=%0d/%0d", bus.perf_fetched, bus.perf_bubbles, m_fet, m_bub); end
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_stall();
      test_redirect();
      test_halt();
      test_random();
      test_async_reset();
`ifdef IF_PERF_CNT_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end
endmodule
